// File: rtl/sm4_pkg.sv
// sm4_pkg: shared definitions for the SM4 round engine.
//   sm4_state_e    - engine FSM states (StIdle, StRun)
//   SM4_ROUNDS     - number of rounds per block
//   sm4_l_data     - linear transform L applied to the S-box output word
//   sm4_rev_words  - reverses the order of the four 32-bit words in a block
package sm4_pkg;

  typedef enum logic [0:0] {StIdle, StRun} sm4_state_e;

  localparam int unsigned SM4_ROUNDS = 32;

  // L(B) = B ^ rol(B,2) ^ rol(B,10) ^ rol(B,18) ^ rol(B,24)
  function automatic logic [31:0] sm4_l_data(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
           {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  function automatic logic [127:0] sm4_rev_words(input logic [127:0] x);
    return {x[31:0], x[63:32], x[95:64], x[127:96]};
  endfunction

endpackage

// File: rtl/sm4_round_f.sv
// sm4_round_f: one combinational SM4 round.
//   x         in  128  state {X0,X1,X2,X3}, X0 = [127:96]
//   rk        in  32   round key for this round
//   sbox_dout in  32   external S-box result for sbox_din
//   sbox_din  out 32   X1 ^ X2 ^ X3 ^ rk, sent to the external S-box
//   x_next    out 128  {X1,X2,X3,X0 ^ L(sbox_dout)}
module sm4_round_f
  import sm4_pkg::*;
(
  input  logic [127:0] x,
  input  logic [31:0]  rk,
  input  logic [31:0]  sbox_dout,
  output logic [31:0]  sbox_din,
  output logic [127:0] x_next
);

  assign sbox_din = x[95:64] ^ x[63:32] ^ x[31:0] ^ rk;
  assign x_next   = {x[95:0], x[127:96] ^ sm4_l_data(sbox_dout)};

endmodule

// File: rtl/sm4_round_engine.sv
// sm4_round_engine: iterative SM4 block cipher core, one round per clock, 33 cycles per block.
// Consumes the 32 round keys from the key expander and drives an external same-cycle S-box.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_key_ok, i_exkey     round keys valid / rk0 = [1023:992] ... rk31 = [31:0]
//   i_din, i_din_en       input block {X0..X3} and its valid strobe
//   i_decrypt             mode, captured together with the block
//   o_din_rdy             engine idle and keys valid
//   o_dout, o_dout_en     registered result {X35..X32} and one-cycle valid pulse
//   o_busy                rounds in progress
//   o_sbox_use/_din       S-box request; i_sbox_dout is the same-cycle answer
// Optional feature: define SM4_CBC_EN to add CBC chaining with ports i_iv and i_iv_load.
module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int unsigned DLY = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_key_ok,
  input  logic [1023:0]   i_exkey,
  input  logic [127:0]    i_din,
  input  logic            i_din_en,
  input  logic            i_decrypt,
  output logic            o_din_rdy,
  output logic [127:0]    o_dout,
  output logic            o_dout_en,
  output logic            o_busy,
  output logic            o_sbox_use,
  output logic [31:0]     o_sbox_din,
  input  logic [31:0]     i_sbox_dout
`ifdef SM4_CBC_EN
  ,
  input  logic [127:0]    i_iv,
  input  logic            i_iv_load
`endif
);

  localparam logic [4:0] LastRound = 5'(SM4_ROUNDS - 1);

  // State updates are zero-delay; DLY is kept only so existing instantiations still elaborate.
  logic unused_dly;
  assign unused_dly = |DLY;

  sm4_state_e   state_q;
  logic [4:0]   round_q;
  logic [127:0] x_q;
  logic         dec_q;
  logic [127:0] dout_q;
  logic         dout_en_q;

  logic         accept;
  logic [4:0]   key_idx;
  logic [9:0]   key_msb;
  logic [31:0]  rk;
  logic [31:0]  round_sbox_din;
  logic [127:0] x_next;
  logic [127:0] result;
  logic [127:0] din_load;
  logic [127:0] dout_next;

  assign o_din_rdy  = (state_q == StIdle) & i_key_ok;
  assign o_busy     = (state_q == StRun);
  assign o_sbox_use = o_busy;
  assign o_sbox_din = o_busy ? round_sbox_din : '0;
  assign o_dout     = dout_q;
  assign o_dout_en  = dout_en_q;

  assign accept = i_din_en & o_din_rdy;

  // Decrypt walks the key list backwards; 31 - r is just ~r on five bits.
  // MSB of rk[k] is 1023 - 32k = {31 - k, 5'h1f}.
  assign key_idx = dec_q ? ~round_q : round_q;
  assign key_msb = {~key_idx, 5'h1f};
  assign rk      = i_exkey[key_msb -: 32];

  sm4_round_f u_round_f (
    .x         (x_q),
    .rk        (rk),
    .sbox_dout (i_sbox_dout),
    .sbox_din  (round_sbox_din),
    .x_next    (x_next)
  );

  assign result = sm4_rev_words(x_next);

`ifdef SM4_CBC_EN
  logic [127:0] chain_q;
  logic [127:0] pend_q;   // ciphertext of the block in flight; becomes chain on completion
  logic [127:0] iv_eff;

  assign iv_eff    = i_iv_load ? i_iv : chain_q;
  assign din_load  = i_decrypt ? i_din : (i_din ^ iv_eff);
  assign dout_next = dec_q ? (result ^ chain_q) : result;
`else
  assign din_load  = i_din;
  assign dout_next = result;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      round_q   <= '0;
      x_q       <= '0;
      dec_q     <= 1'b0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
`ifdef SM4_CBC_EN
      chain_q   <= '0;
      pend_q    <= '0;
`endif
    end else begin
      dout_en_q <= 1'b0;
      case (state_q)
        StIdle: begin
`ifdef SM4_CBC_EN
          // Chain holds the IV used by the next block; an abort leaves it untouched.
          if (i_iv_load) chain_q <= i_iv;
`endif
          if (accept) begin
            x_q     <= din_load;
            dec_q   <= i_decrypt;
            round_q <= '0;
            state_q <= StRun;
`ifdef SM4_CBC_EN
            pend_q  <= i_din;
`endif
          end
        end
        StRun: begin
          if (!i_key_ok) begin
            state_q <= StIdle;
          end else begin
            x_q <= x_next;
            if (round_q == LastRound) begin
              round_q   <= '0;
              state_q   <= StIdle;
              dout_q    <= dout_next;
              dout_en_q <= 1'b1;
`ifdef SM4_CBC_EN
              chain_q   <= dec_q ? pend_q : result;
`endif
            end else begin
              round_q <= round_q + 5'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
